// File: rtl/memoria_ram_bist.sv
`default_nettype none
// ============================================================================
// Module      : memoria_ram_bist
// Description : Built-in self-test initiator for one MemoriaRAM instance.
//               On start it runs a four-phase march over every address:
//               write P(a), read/compare P(a), write ~P(a), read/compare
//               ~P(a), where P(a) = a ^ PAT. It then reports pass/fail, the
//               number of mismatching reads and the first failing location.
//
// Ports       : clk_i         system clock (rising edge)
//               rst_i         synchronous reset, active low
//               start_i       start request, honoured in IDLE or DONE only
//               addr_o        RAM address
//               rden_o        RAM read enable
//               wren_o        RAM write enable
//               dato_write_o  RAM write data
//               dato_read_i   RAM read data (combinational from the RAM)
//               busy_o        march in progress
//               done_o        march finished, results valid
//               pass_o        finished with zero mismatches
//               err_count_o   number of mismatching reads
//               fail_addr_o   address of the first mismatch
//               fail_phase_o  phase of the first mismatch (0 = RD0, 1 = RD1)
//
// Revision    : 1.0 - initial release
// ============================================================================
module memoria_ram_bist #(
  parameter int             N   = 4,
  parameter int             M   = 4,
  parameter logic [M-1:0]   PAT = 4'hA
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  output logic [N-1:0]     addr_o,
  output logic             rden_o,
  output logic             wren_o,
  output logic [M-1:0]     dato_write_o,
  input  logic [M-1:0]     dato_read_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             pass_o,
  output logic [N+1:0]     err_count_o,
  output logic [N-1:0]     fail_addr_o,
  output logic             fail_phase_o
);

  // --------------------------------------------------------------------------
  // State encoding
  // --------------------------------------------------------------------------
  localparam logic [2:0] c_ST_IDLE = 3'd0;
  localparam logic [2:0] c_ST_WR0  = 3'd1;
  localparam logic [2:0] c_ST_RD0  = 3'd2;
  localparam logic [2:0] c_ST_WR1  = 3'd3;
  localparam logic [2:0] c_ST_RD1  = 3'd4;
  localparam logic [2:0] c_ST_DONE = 3'd5;

  localparam logic [N-1:0] c_CNT_LAST = {N{1'b1}};

  // --------------------------------------------------------------------------
  // Registered state
  // --------------------------------------------------------------------------
  logic [2:0]   r_state;
  logic [N-1:0] r_cnt;
  logic [N+1:0] r_err;
  logic [N-1:0] r_fail_addr;
  logic         r_fail_phase;
  logic         r_done;
  logic         r_pass;

  // --------------------------------------------------------------------------
  // Combinational decode (from registered state/counter only on the RAM side)
  // --------------------------------------------------------------------------
  logic [M-1:0] w_cnt_ext;
  logic [M-1:0] w_pat;
  logic [M-1:0] w_expect;
  logic         w_is_wr;
  logic         w_is_rd;
  logic         w_busy;
  logic         w_rd_ok;
  logic         w_mismatch;
  logic         w_cnt_last;
  logic [N+1:0] w_err_next;

  // The address is zero-extended or truncated to the data width before the
  // seed is applied.
  generate
    if (M > N) begin : g_ext_pad
      assign w_cnt_ext = {{(M-N){1'b0}}, r_cnt};
    end else begin : g_ext_trunc
      assign w_cnt_ext = r_cnt[M-1:0];
    end
  endgenerate

  assign w_pat      = w_cnt_ext ^ PAT;
  assign w_is_wr    = (r_state == c_ST_WR0) || (r_state == c_ST_WR1);
  assign w_is_rd    = (r_state == c_ST_RD0) || (r_state == c_ST_RD1);
  assign w_busy     = w_is_wr || w_is_rd;
  assign w_cnt_last = (r_cnt == c_CNT_LAST);
  assign w_expect   = (r_state == c_ST_RD1) ? ~w_pat : w_pat;
  assign w_rd_ok    = (dato_read_i == w_expect);

  // Written as "ok or not reading, else mismatch" so that an unknown compare
  // result falls into the mismatch branch.
  always_comb begin
    w_mismatch = 1'b0;
    if (!w_is_rd || w_rd_ok) begin
      w_mismatch = 1'b0;
    end else begin
      w_mismatch = 1'b1;
    end
  end

  // Error count including the compare performed at the current edge; used so
  // that the pass flag at the final RD1 edge sees the last read too.
  assign w_err_next = w_mismatch ? (r_err + (N+2)'(1)) : r_err;

  // --------------------------------------------------------------------------
  // March sequencer
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state      <= c_ST_IDLE;
      r_cnt        <= '0;
      r_err        <= '0;
      r_fail_addr  <= '0;
      r_fail_phase <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
    end else begin
      case (r_state)
        c_ST_IDLE, c_ST_DONE: begin
          // DONE holds results until a new start; restart clears them.
          if (start_i) begin
            r_state      <= c_ST_WR0;
            r_cnt        <= '0;
            r_err        <= '0;
            r_fail_addr  <= '0;
            r_fail_phase <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
          end
        end

        c_ST_WR0, c_ST_RD0, c_ST_WR1, c_ST_RD1: begin
          // Counter wraps naturally to zero at the phase boundary.
          r_cnt <= r_cnt + N'(1);

          if (w_mismatch) begin
            r_err <= w_err_next;
            // Only the first mismatch of a run is captured.
            if (r_err == '0) begin
              r_fail_addr  <= r_cnt;
              r_fail_phase <= (r_state == c_ST_RD1);
            end
          end

          if (w_cnt_last) begin
            case (r_state)
              c_ST_WR0: r_state <= c_ST_RD0;
              c_ST_RD0: r_state <= c_ST_WR1;
              c_ST_WR1: r_state <= c_ST_RD1;
              default: begin
                r_state <= c_ST_DONE;
                r_done  <= 1'b1;
                r_pass  <= (w_err_next == '0);
              end
            endcase
          end
        end

        default: begin
          r_state <= c_ST_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign addr_o       = w_busy ? r_cnt : '0;
  assign wren_o       = w_is_wr;
  assign rden_o       = w_is_rd;
  assign dato_write_o = (r_state == c_ST_WR0) ? w_pat  :
                        (r_state == c_ST_WR1) ? ~w_pat : '0;

  assign busy_o       = w_busy;
  assign done_o       = r_done;
  assign pass_o       = r_pass;
  assign err_count_o  = r_err;
  assign fail_addr_o  = r_fail_addr;
  assign fail_phase_o = r_fail_phase;

endmodule
`default_nettype wire

// File: tb/tb_memoria_ram_bist.sv
`default_nettype none
// ============================================================================
// Module      : tb_memoria_ram_bist
// Description : Self-checking bench for memoria_ram_bist. A behavioural RAM
//               with per-address read masks (stuck-at faults) sits behind the
//               default-parameter DUT; a second DUT (N=3, M=8, PAT=8'h5C)
//               covers the parameter sweep. Expected results come from a
//               loop-level model of the march over the fault masks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_memoria_ram_bist;

  localparam int           N     = 4;
  localparam int           M     = 4;
  localparam logic [M-1:0] PAT   = 4'hA;
  localparam int           DEPTH = 16;
  localparam int           N2    = 3;
  localparam int           M2    = 8;
  localparam int           DEPTH2 = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic start;
  logic start2;

  // Default-parameter DUT
  logic [N-1:0]   addr;
  logic           rden, wren;
  logic [M-1:0]   wdat, rdat;
  logic           busy, done, pass;
  logic [N+1:0]   errc;
  logic [N-1:0]   faddr;
  logic           fphase;

  // Sweep DUT
  logic [N2-1:0]  addr2;
  logic           rden2, wren2;
  logic [M2-1:0]  wdat2, rdat2;
  logic           busy2, done2, pass2;
  logic [N2+1:0]  errc2;
  logic [N2-1:0]  faddr2;
  logic           fphase2;

  memoria_ram_bist #(.N(N), .M(M), .PAT(PAT)) u_dut (
    .clk_i(clk), .rst_i(rst_n), .start_i(start),
    .addr_o(addr), .rden_o(rden), .wren_o(wren),
    .dato_write_o(wdat), .dato_read_i(rdat),
    .busy_o(busy), .done_o(done), .pass_o(pass),
    .err_count_o(errc), .fail_addr_o(faddr), .fail_phase_o(fphase)
  );

  memoria_ram_bist #(.N(N2), .M(M2), .PAT(8'h5C)) u_dut_sweep (
    .clk_i(clk), .rst_i(rst_n), .start_i(start2),
    .addr_o(addr2), .rden_o(rden2), .wren_o(wren2),
    .dato_write_o(wdat2), .dato_read_i(rdat2),
    .busy_o(busy2), .done_o(done2), .pass_o(pass2),
    .err_count_o(errc2), .fail_addr_o(faddr2), .fail_phase_o(fphase2)
  );

  // Behavioural RAMs: synchronous write, combinational read through masks.
  logic [M-1:0]  mem    [DEPTH];
  logic [M-1:0]  and_m  [DEPTH];
  logic [M-1:0]  or_m   [DEPTH];
  logic [M2-1:0] mem2   [DEPTH2];

  always @(posedge clk) begin
    if (wren) mem[addr] <= wdat;
    if (wren2) mem2[addr2] <= wdat2;
  end

  assign rdat  = (mem[addr] & and_m[addr]) | or_m[addr];
  assign rdat2 = mem2[addr2];

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_faults();
    for (int a = 0; a < DEPTH; a++) begin
      and_m[a] = '1;
      or_m[a]  = '0;
    end
  endtask

  // Reference: walk both read phases over every address with the written
  // pattern and the fault masks, counting mismatches and the first one.
  task automatic model(output int e_err, output int e_addr, output int e_ph);
    logic [M-1:0] p;
    logic [M-1:0] rd;
    e_err = 0; e_addr = 0; e_ph = 0;
    for (int ph = 0; ph < 2; ph++) begin
      for (int a = 0; a < DEPTH; a++) begin
        p = M'(a) ^ PAT;
        if (ph == 1) p = ~p;
        rd = (p & and_m[a]) | or_m[a];
        if (rd != p) begin
          if (e_err == 0) begin
            e_addr = a;
            e_ph   = ph;
          end
          e_err++;
        end
      end
    end
  endtask

  // One full march on the default DUT. pulse_at >= 0 re-pulses start at that
  // cycle of the run; hold keeps start high across completion.
  task automatic run_march(input string tag, input int pulse_at, input bit hold);
    int k, e_err, e_addr, e_ph, bus_bad, ph, a, w;
    bit seen;
    logic [M-1:0] pp, exp_d;
    logic exp_w, exp_r;
    model(e_err, e_addr, e_ph);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    if (!hold) start = 1'b0;
    check({tag, "/clr_done"}, 32'(done), 32'd0);
    check({tag, "/clr_err"},  32'(errc), 32'd0);
    k = 0; bus_bad = 0; seen = 1'b0;
    while (k < 200) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      ph = k / DEPTH;
      a  = k % DEPTH;
      pp = M'(a) ^ PAT;
      exp_w = (ph == 0) || (ph == 2);
      exp_r = (ph == 1) || (ph == 3);
      exp_d = (ph == 0) ? pp : (ph == 2) ? ~pp : '0;
      if (wren !== exp_w || rden !== exp_r || addr !== N'(a) || wdat !== exp_d || busy !== 1'b1)
        bus_bad++;
      if (k == pulse_at) start = 1'b1;
      else if (!hold) start = 1'b0;
      k++;
      @(negedge clk);
    end
    check({tag, "/latency"}, 32'(k), 32'd64);
    check({tag, "/bus_seq"}, 32'(bus_bad), 32'd0);
    check({tag, "/err"},     32'(errc), 32'(e_err));
    check({tag, "/faddr"},   32'(faddr), 32'(e_addr));
    check({tag, "/fphase"},  32'(fphase), 32'(e_ph));
    check({tag, "/pass"},    32'(pass), (e_err == 0) ? 32'd1 : 32'd0);
    if (hold) begin
      @(negedge clk);
      check({tag, "/hold_restart"}, 32'({busy, done}), 32'b10);
      start = 1'b0;
      seen = 1'b0;
      for (w = 0; w < 100; w++) begin
        @(negedge clk);
        if (done) begin
          seen = 1'b1;
          break;
        end
      end
      check({tag, "/hold_done"}, 32'(seen), 32'd1);
    end
  endtask

  initial begin
    int bad, k;
    logic [M2-1:0] d23;
    logic w23;
    logic [N2-1:0] a23;
    clear_faults();
    rst_n = 1'b0; start = 1'b0; start2 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst/state", 32'({busy, done, pass, wren, rden}), 32'd0);
    check("rst/addr_data", 32'({addr, wdat}), 32'd0);
    check("rst/results", 32'({errc, faddr, fphase}), 32'd0);
    rst_n = 1'b1;

    run_march("ideal", -1, 1'b0);

    and_m[5] = 4'hE;
    run_march("stuck5", -1, 1'b0);
    check("stuck5/spec", 32'({errc, faddr, fphase, pass}), 32'({6'd1, 4'd5, 1'b0, 1'b0}));

    clear_faults();
    and_m[0] = '0; and_m[1] = '0; and_m[8] = '0;
    and_m[9] = '0; and_m[10] = '0; and_m[14] = '0;
    run_march("memoria", -1, 1'b0);
    check("memoria/spec", 32'({errc, faddr, fphase, pass}), 32'({6'd11, 4'd0, 1'b0, 1'b0}));

    // Restart from DONE (with errors held) and an ignored start at cycle 20.
    clear_faults();
    run_march("rerun", 20, 1'b0);
    run_march("hold", -1, 1'b1);

    for (int it = 0; it < 6; it++) begin
      clear_faults();
      for (int a = 0; a < DEPTH; a++) begin
        if ($urandom_range(0, 3) == 0) begin
          and_m[a] = M'($urandom);
          or_m[a]  = M'($urandom);
        end
      end
      run_march($sformatf("rand%0d", it), -1, 1'b0);
    end

    // Reset during RD0 at cnt=7 with an earlier error recorded.
    clear_faults();
    and_m[2] = '0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (23) @(negedge clk);
    check("midrst/rd0_cnt7", 32'({rden, wren, addr}), 32'({1'b1, 1'b0, 4'd7}));
    check("midrst/err_before", 32'(errc), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst/after", 32'({busy, done, wren, rden, errc}), 32'd0);
    rst_n = 1'b1;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (wren || rden || busy || done) bad++;
    end
    check("midrst/quiet", 32'(bad), 32'd0);

    // Parameter sweep instance.
    @(negedge clk); start2 = 1'b1;
    @(negedge clk); start2 = 1'b0;
    k = 0; d23 = '0; w23 = 1'b0; a23 = '0;
    while (k < 100 && !done2) begin
      if (k == 2 * DEPTH2 + 7) begin
        d23 = wdat2; w23 = wren2; a23 = addr2;
      end
      k++;
      @(negedge clk);
    end
    check("sweep/latency", 32'(k), 32'd32);
    check("sweep/result", 32'({pass2, errc2}), 32'({1'b1, 5'd0}));
    check("sweep/wr1_a7", 32'({w23, a23, d23}), 32'({1'b1, 3'd7, 8'hA4}));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/memoria_ram_bist.md
Name: memoria_ram_bist

Overview:
- Built-in self-test initiator that drives the separate read/write port interface of the team's MemoriaRAM (addr, rden, wren, write data, combinational read data).
- On a start request it runs a four-phase march over every address:
  - write a pattern;
  - read and compare;
  - write the complement;
  - read and compare.
- It then reports pass/fail, an error count and the first failing location.
- Sits between a test controller and one RAM instance; the RAM's ports connect 1:1 to this block's memory-side ports.

Parameters:
- N, 4, address width; RAM depth is 2**N.
- M, 4, data width.
- PAT, 4'hA, M-bit seed XORed into the address to form the test pattern.

Ports:
- clk_i  input  1  system clock, all state updates on rising edge
- rst_i  input  1  synchronous, active-low reset (sampled on rising clk_i; 0 = reset)
- start_i  input  1  start request, level-sampled, honoured only in IDLE or DONE
- addr_o  output  N  RAM address
- rden_o  output  1  RAM read enable
- wren_o  output  1  RAM write enable
- dato_write_o  output  M  RAM write data
- dato_read_i  input  M  RAM read data (combinational from RAM; valid in the same cycle as addr_o/rden_o)
- busy_o  output  1  test in progress (WR0, RD0, WR1, RD1)
- done_o  output  1  test finished, results valid; held until restart or reset
- pass_o  output  1  1 when done_o=1 and err_count_o=0
- err_count_o  output  N+2  number of mismatching reads (max 2**(N+1), no saturation needed)
- fail_addr_o  output  N  address of first mismatch
- fail_phase_o  output  1  phase of first mismatch (0 = RD0, 1 = RD1)

Behaviour:
- Reset (rst_i=0 at a clock edge): state=IDLE, address counter=0, all outputs 0. Reset mid-test aborts immediately; no further RAM writes after that edge.
- Pattern: P(a) = (a zero-extended or truncated to M bits) XOR PAT. Complement pattern: ~P(a).
- Memory-side outputs are decoded from registered state and counter only; no combinational path from any input to addr_o, rden_o, wren_o or dato_write_o.
- States and per-cycle memory drive:
  - IDLE: rden_o=0, wren_o=0, addr_o=0, dato_write_o=0. On start_i=1: counter:=0, clear err_count/fail_addr/fail_phase/done, go to WR0.
  - WR0: wren_o=1, rden_o=0, addr_o=cnt, dato_write_o=P(cnt). One address per cycle.
  - RD0: rden_o=1, wren_o=0, addr_o=cnt, dato_write_o=0. At each edge compare dato_read_i against P(cnt).
  - WR1: as WR0 but dato_write_o=~P(cnt).
  - RD1: as RD0, comparing against ~P(cnt).
  - DONE: memory outputs idle as in IDLE; done_o=1, busy_o=0. start_i=1 restarts exactly as from IDLE.
- Phase advance: at the edge where cnt = 2**N-1, cnt wraps to 0 and state advances WR0→RD0→WR1→RD1→DONE.
- Latency: start sampled at edge E0. WR0 covers cycles E0..E0+2**N; RD1 ends at edge E0+4*2**N, where done_o rises. Default params: 64 cycles.
- Mismatch handling:
  - Each mismatch increments err_count_o by 1.
  - On the first mismatch of a run (err_count_o==0 before the increment), capture fail_addr_o=cnt and fail_phase_o (RD0→0, RD1→1).
  - Later mismatches do not overwrite the capture.
- pass_o = done_o & (err_count_o==0), registered. err_count_o, fail_addr_o and fail_phase_o hold their values through DONE.
- start_i while busy is ignored; start_i held high continuously restarts once per completion (DONE→WR0 on the next edge).
- Compare uses all M bits; X on dato_read_i counts as a mismatch in simulation only, no special RTL handling.

Test Plan:
- Ideal behavioural RAM, N=4, M=4, PAT=4'hA: pulse start_i → 16 writes of a^A, 16 compare reads, 16 writes of a^5, 16 reads; done_o rises 64 cycles after start; pass_o=1, err_count_o=0.
- Ideal RAM with bit0 of address 5 stuck at 0: RD0 expects F, reads E → err_count_o=1, fail_addr_o=5, fail_phase_o=0; RD1 expects 0, reads 0 (no error); pass_o=0.
- Connected to MemoriaRAM (N=4, M=4) after its reset, so addresses 0, 1, 8, 9, 10 and 14 read 0:
  - RD0 fails at 0, 1, 8, 9, 14 (address 10 expects 0);
  - RD1 fails at all six addresses;
  - result: err_count_o=11, fail_addr_o=0, fail_phase_o=0, pass_o=0.
- start_i pulsed again at cycle 20 of a run → ignored; done still at cycle 64. start_i pulsed in DONE → done_o, pass_o and err_count_o clear next edge, full 64-cycle rerun.
- rst_i driven low during RD0 (cnt=7) → next edge: IDLE, wren_o=rden_o=0, busy_o=0, done_o=0, err_count_o=0; no further RAM accesses until a new start_i.
- Parameter sweep N=3, M=8, PAT=8'h5C with ideal RAM → done after 32 cycles, pass_o=1; write data on address 7 in WR1 is ~(8'h07^8'h5C)=8'hA4.
